// File: rtl/mpadd8_seq_if.sv
// Byte-serial operand, adder and result signals for mpadd8_seq.
// The slave side is the sequencer; the master side is the source, adder and sink.
interface mpadd8_seq_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_sub;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_ci;
   logic [7:0] add_s;
   logic       add_co;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_s;
   logic       out_last;
   logic       out_co;

   modport slave (
      input  in_valid, in_a, in_b, in_sub, add_s, add_co, out_ready,
      output in_ready, add_a, add_b, add_ci, out_valid, out_s, out_last, out_co
   );

   modport master (
      output in_valid, in_a, in_b, in_sub, add_s, add_co, out_ready,
      input  in_ready, add_a, add_b, add_ci, out_valid, out_s, out_last, out_co
   );
endinterface

// File: rtl/mpadd8_seq.sv
// Multi-precision add/subtract sequencer driving an external 8-bit ripple adder.
// One byte in flight; carry chained LSB-first across NBYTES bytes.
module mpadd8_seq #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned SETTLE = 2
) (
   input logic          clk,
   input logic          reset,
   mpadd8_seq_if.slave  bus
);

   localparam int unsigned IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   typedef enum logic [1:0] {st_idle, st_settle, st_out} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [3:0]    cnt;
   logic          carry;
   logic          mode;

   assign bus.in_ready = (state == st_idle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= st_idle;
         idx           <= '0;
         cnt           <= '0;
         carry         <= 1'b0;
         mode          <= 1'b0;
         bus.add_a     <= 8'h00;
         bus.add_b     <= 8'h00;
         bus.add_ci    <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_s     <= 8'h00;
         bus.out_last  <= 1'b0;
         bus.out_co    <= 1'b0;
      end else begin
         unique case (state)
            st_idle: begin
               if (bus.in_valid) begin
                  bus.add_a <= bus.in_a;
                  cnt       <= CNT_INIT;
                  state     <= st_settle;
                  // Byte 0 fixes the mode and seeds CI (1 for two's-complement subtract).
                  if (idx == '0) begin
                     mode       <= bus.in_sub;
                     bus.add_b  <= bus.in_sub ? ~bus.in_b : bus.in_b;
                     bus.add_ci <= bus.in_sub;
                  end else begin
                     bus.add_b  <= mode ? ~bus.in_b : bus.in_b;
                     bus.add_ci <= carry;
                  end
               end
            end
            st_settle: begin
               if (cnt == 4'd0) begin
                  bus.out_s     <= bus.add_s;
                  carry         <= bus.add_co;
                  bus.out_last  <= (idx == LAST_IDX);
                  bus.out_co    <= (idx == LAST_IDX) ? bus.add_co : 1'b0;
                  bus.out_valid <= 1'b1;
                  state         <= st_out;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            st_out: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.out_last  <= 1'b0;
                  bus.out_co    <= 1'b0;
                  state         <= st_idle;
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     carry <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_mpadd8_seq.sv
// Directed bench for mpadd8_seq with a transport-delayed 8-bit adder model.
module tb_mpadd8_seq;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [8:0] sum_d = 9'h000;

   mpadd8_seq_if bus();

   mpadd8_seq #(.NBYTES(4), .SETTLE(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Adder result appears 1.5 cycles after its inputs change.
   always @(bus.add_a or bus.add_b or bus.add_ci)
      sum_d <= #15 {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_ci};
   assign bus.add_s  = sum_d[7:0];
   assign bus.add_co = sum_d[8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One byte through the sequencer: accept, check adder drive, latency, result, release.
   task automatic do_byte(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] exp_b, input logic exp_ci,
                          input logic [7:0] exp_s, input logic exp_last, input logic exp_co,
                          input int hold);
      int c;
      c = 0;
      @(negedge clk);
      while (!bus.in_ready && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk({tag, ".rdy"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sub   = 1'b0;
      chk({tag, ".drv"}, {15'd0, bus.add_a, exp_b, exp_ci}, {15'd0, a, exp_b, exp_ci});
      chk({tag, ".drv_b"}, {23'd0, bus.add_b, bus.add_ci}, {23'd0, exp_b, exp_ci});
      c = 0;
      do begin
         @(posedge clk);
         #1;
         c++;
      end while (!bus.out_valid && c < 20);
      chk({tag, ".lat"}, c, 32'd2);
      chk({tag, ".out"}, {21'd0, bus.out_valid, bus.out_s, bus.out_last, bus.out_co},
          {21'd0, 1'b1, exp_s, exp_last, exp_co});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s.hold%0d", tag, i),
             {20'd0, bus.out_valid, bus.out_s, bus.out_last, bus.out_co, bus.in_ready},
             {20'd0, 1'b1, exp_s, exp_last, exp_co, 1'b0});
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, ".done"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_vals", {4'd0, bus.out_valid, bus.out_s, bus.out_last, bus.out_co, bus.add_a,
                         bus.add_b, bus.add_ci, bus.in_ready}, {4'd0, 28'h000_0001});
      @(negedge clk);
      reset = 1'b0;

      // 0x01FFFFFF + 0x00000001
      do_byte("add0", 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("add1", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_byte("add2", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_byte("add3", 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 0);

      // 5 - 7 borrows; later bytes present in_sub=0 which must be ignored
      do_byte("sub0", 8'h05, 8'h07, 1'b1, 8'hF8, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
      do_byte("sub1", 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
      do_byte("sub2", 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
      do_byte("sub3", 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 0);

      // 7 - 5, with backpressure on the last byte
      do_byte("sbb0", 8'h07, 8'h05, 1'b1, 8'hFA, 1'b1, 8'h02, 1'b0, 1'b0, 0);
      do_byte("sbb1", 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_byte("sbb2", 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_byte("sbb3", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 10);

      // Reset during SETTLE of byte 2
      do_byte("rst0", 8'h11, 8'h22, 1'b0, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 0);
      do_byte("rst1", 8'h11, 8'h22, 1'b0, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 8'h44;
      bus.in_b     = 8'h55;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("rst_async", {4'd0, bus.out_valid, bus.out_s, bus.out_last, bus.out_co, bus.add_a,
                        bus.add_b, bus.add_ci, bus.in_ready}, {4'd0, 28'h000_0001});
      @(negedge clk);
      reset = 1'b0;
      do_byte("new0", 8'h80, 8'h80, 1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("new1", 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
      do_byte("new2", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("new3", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0);

      // Back-to-back: FFFFFFFF + 1 then 0 + 0
      do_byte("bb0", 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("bb1", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_byte("bb2", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      do_byte("bb3", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 0);
      do_byte("bz0", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("bz1", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("bz2", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      do_byte("bz3", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
